// File: rtl/mem_bus_pkg.sv
// Shared types for the CPU-to-memory word bus.
// Op and state encodings, address widths.
package mem_bus_pkg;

  localparam int WADDR_W = 17;
  localparam int BADDR_W = 19;

  typedef enum logic [1:0] {
    OP_WRD = 2'b00,
    OP_RDB = 2'b01,
    OP_WRW = 2'b10,
    OP_WRB = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    MERGE  = 2'b10,
    DONE   = 2'b11
  } state_e;

endpackage

// File: rtl/byte_lane.sv
// Big-endian byte lane helper: lane 0 is bits 0:7.
// Extracts one lane and merges a byte into a word.
module byte_lane (
  input  logic [0:31] word,
  input  logic [1:0]  lane,
  input  logic [0:7]  byte_in,
  output logic [0:7]  byte_out,
  output logic [0:31] merged
);

  logic [4:0] base;

  assign base = {lane, 3'b000};

  // Select the addressed lane and splice the new byte in
  always_comb begin
    byte_out = word[base +: 8];
    merged = word;
    merged[base +: 8] = byte_in;
  end

endmodule

// File: rtl/mem_initiator.sv
// Bus initiator: CPU requests to word memory, with byte RMW.
// Optional halt detector under SIM_HALT_EN.
module mem_initiator
  import mem_bus_pkg::*;
#(
  parameter int unsigned READ_WAIT = 0
`ifdef SIM_HALT_EN
  ,
  parameter logic [WADDR_W-1:0] HALT_ADDR = 17'h00100,
  parameter logic [31:0] HALT_DATA = 32'h00010001
`endif
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req,
  input  logic [0:1]            op,
  input  logic [32-BADDR_W:31]  byte_addr,
  input  logic [0:31]           wdata,
  output logic                  busy,
  output logic                  done,
  output logic [0:31]           rdata,
  output logic [32-WADDR_W:31]  mem_address,
  output logic                  mem_write_en,
  output logic [0:31]           mem_data_out,
  input  logic [0:31]           mem_data_in
`ifdef SIM_HALT_EN
  ,
  output logic                  halted
`endif
);

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [32-WADDR_W:31] waddr_q, waddr_d;
  logic [1:0]          lane_q, lane_d;
  logic [0:31]         wdata_q, wdata_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [0:31]         capt_q, capt_d;
  logic [0:31]         rdata_q, rdata_d;

  logic        blocked;
  logic [0:31] lane_word;
  logic [0:7]  lane_byte;
  logic [0:31] merged;

  assign lane_word = (state_q == MERGE) ? capt_q : mem_data_in;

  byte_lane u_lane (
    .word     (lane_word),
    .lane     (lane_q),
    .byte_in  (wdata_q[24:31]),
    .byte_out (lane_byte),
    .merged   (merged)
  );

`ifdef SIM_HALT_EN
  logic halted_q, halted_d;

  // Sticky flag on a committed write of the halt pattern
  always_comb begin
    halted_d = halted_q;
    if (mem_write_en && mem_address == HALT_ADDR &&
        mem_data_out == HALT_DATA)
      halted_d = 1'b1;
  end

  // Halt flag register, cleared only by reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) halted_q <= 1'b0;
    else       halted_q <= halted_d;
  end

  assign halted  = halted_q;
  assign blocked = halted_q;
`else
  assign blocked = 1'b0;
`endif

  // FSM state and latched request fields
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= OP_WRD;
      waddr_q <= '0;
      lane_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      capt_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      waddr_q <= waddr_d;
      lane_q  <= lane_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      capt_q  <= capt_d;
      rdata_q <= rdata_d;
    end
  end

  // Next state, field updates and bus decode from registered state
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    waddr_d      = waddr_q;
    lane_d       = lane_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    capt_d       = capt_q;
    rdata_d      = rdata_q;
    busy         = blocked;
    done         = 1'b0;
    mem_write_en = 1'b0;
    mem_data_out = '0;

    unique case (state_q)
      IDLE, DONE: begin
        done    = (state_q == DONE);
        state_d = IDLE;
        if (req && !blocked) begin
          op_d    = op_e'(op);
          waddr_d = byte_addr[32-BADDR_W:29];
          lane_d  = byte_addr[30:31];
          wdata_d = wdata;
          cnt_d   = 4'(READ_WAIT);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        busy = 1'b1;
        if (op_q == OP_WRW) begin
          mem_write_en = 1'b1;
          mem_data_out = wdata_q;
          state_d      = DONE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          case (op_q)
            OP_WRD: begin
              rdata_d = mem_data_in;
              state_d = DONE;
            end
            OP_RDB: begin
              rdata_d = {24'h0, lane_byte};
              state_d = DONE;
            end
            OP_WRB: begin
              capt_d  = mem_data_in;
              state_d = MERGE;
            end
            default: state_d = DONE;
          endcase
        end
      end
      MERGE: begin
        busy         = 1'b1;
        mem_write_en = 1'b1;
        mem_data_out = merged;
        state_d      = DONE;
      end
    endcase
  end

  assign mem_address = waddr_q;
  assign rdata       = rdata_q;

endmodule

// File: tb/tb_mem_initiator.sv
// Self-checking bench for mem_initiator.
// Build with +define+SIM_HALT_EN to cover the halt detector.
module tb_mem_initiator;
  import mem_bus_pkg::*;

  typedef struct {
    logic [0:31] rd;
    int          lat;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        req;
  logic [0:1]  op;
  logic [13:31] byte_addr;
  logic [0:31] wdata;
  logic        busy, done;
  logic [0:31] rdata;
  logic [15:31] mem_address;
  logic        mem_write_en;
  logic [0:31] mem_data_out, mem_data_in;
  logic        halted;

  logic        d2_req;
  logic [0:1]  d2_op;
  logic [13:31] d2_addr;
  logic [0:31] d2_wdata;
  logic        d2_busy, d2_done;
  logic [0:31] d2_rdata;
  logic [15:31] d2_maddr;
  logic        d2_we;
  logic [0:31] d2_mout, d2_min;
  logic        d2_halted;

  logic [0:31] mem [0:131071];
  int          wr_cnt = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];

  always #5 clock = ~clock;

  mem_initiator dut (
    .clock        (clock),
    .reset        (reset),
    .req          (req),
    .op           (op),
    .byte_addr    (byte_addr),
    .wdata        (wdata),
    .busy         (busy),
    .done         (done),
    .rdata        (rdata),
    .mem_address  (mem_address),
    .mem_write_en (mem_write_en),
    .mem_data_out (mem_data_out),
    .mem_data_in  (mem_data_in)
`ifdef SIM_HALT_EN
    ,
    .halted       (halted)
`endif
  );

  mem_initiator #(.READ_WAIT(3)) dut2 (
    .clock        (clock),
    .reset        (reset),
    .req          (d2_req),
    .op           (d2_op),
    .byte_addr    (d2_addr),
    .wdata        (d2_wdata),
    .busy         (d2_busy),
    .done         (d2_done),
    .rdata        (d2_rdata),
    .mem_address  (d2_maddr),
    .mem_write_en (d2_we),
    .mem_data_out (d2_mout),
    .mem_data_in  (d2_min)
`ifdef SIM_HALT_EN
    ,
    .halted       (d2_halted)
`endif
  );

`ifndef SIM_HALT_EN
  assign halted    = 1'b0;
  assign d2_halted = 1'b0;
`endif

  assign mem_data_in = mem[mem_address];

  always @(posedge clock) begin
    if (mem_write_en) mem[mem_address] = mem_data_out;
  end

  always @(posedge clock) begin
    if (mem_write_en) wr_cnt <= wr_cnt + 1;
  end

  task automatic drive(input logic [0:1] o,
                       input logic [13:31] a,
                       input logic [0:31] d);
    @(negedge clock);
    req = 1'b1;
    op = o;
    byte_addr = a;
    wdata = d;
    @(posedge clock);
    #1 req = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    repeat (40) begin
      @(negedge clock);
      if (done) return;
      lat++;
    end
    lat = -1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if ({busy, done, mem_write_en} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctl got %b want 000",
               {busy, done, mem_write_en});
    end
    checks++;
    if (rdata !== 32'h0 || mem_data_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_data got %h/%h want 0/0",
               rdata, mem_data_out);
    end
    checks++;
    if (mem_address !== 17'h0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL reset_addr got %h/%b want 0/0",
               mem_address, halted);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_word;
    exp_t e;
    int lat;
    sb.push_back('{32'h0, 2});
    drive(OP_WRW, 19'h00040, 32'hDEADBEEF);
    wait_done(lat);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat) begin
      errors++;
      $display("FAIL wrw_lat got %0d want %0d", lat, e.lat);
    end
    checks++;
    if (rdata !== e.rd) begin
      errors++;
      $display("FAIL wrw_rdata got %h want %h", rdata, e.rd);
    end
    checks++;
    if (mem[17'h010] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wrw_mem got %h want deadbeef",
               mem[17'h010]);
    end
    sb.push_back('{32'hDEADBEEF, 2});
    drive(OP_WRD, 19'h00040, 32'h0);
    wait_done(lat);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat || rdata !== e.rd) begin
      errors++;
      $display("FAIL rdw got %h lat %0d want %h lat %0d",
               rdata, lat, e.rd, e.lat);
    end
  endtask

  task automatic test_byte_read;
    exp_t e;
    int lat;
    logic [0:31] w;
    w = 32'h11223344;
    @(negedge clock);
    mem[17'h010] = w;
    for (int l = 0; l < 4; l++) begin
      sb.push_back('{(w >> (8 * (3 - l))) & 32'hFF, 2});
      drive(OP_RDB, 19'h00040 + 19'(l), 32'hFFFFFFFF);
      wait_done(lat);
      e = sb.pop_front();
      checks++;
      if (lat !== e.lat || rdata !== e.rd) begin
        errors++;
        $display("FAIL rdb_lane%0d got %h lat %0d want %h lat %0d",
                 l, rdata, lat, e.rd, e.lat);
      end
    end
  endtask

  task automatic test_byte_write;
    exp_t e;
    int lat;
    int w0;
    @(negedge clock);
    mem[17'h010] = 32'h11223344;
    w0 = wr_cnt;
    sb.push_back('{32'h00000044, 3});
    drive(OP_WRB, 19'h00042, 32'h555555AA);
    wait_done(lat);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat) begin
      errors++;
      $display("FAIL wrb_lat got %0d want %0d", lat, e.lat);
    end
    checks++;
    if (mem[17'h010] !== 32'h1122AA44) begin
      errors++;
      $display("FAIL wrb_mem got %h want 1122aa44",
               mem[17'h010]);
    end
    checks++;
    if (wr_cnt - w0 !== 1) begin
      errors++;
      $display("FAIL wrb_we_cycles got %0d want 1", wr_cnt - w0);
    end
    checks++;
    if (rdata !== e.rd) begin
      errors++;
      $display("FAIL wrb_rdata got %h want %h", rdata, e.rd);
    end
  endtask

  task automatic test_read_wait;
    exp_t e;
    int lat;
    logic [15:31] a_seen;
    sb.push_back('{32'hCAFEF00D, 5});
    @(negedge clock);
    d2_req = 1'b1;
    d2_op = OP_WRD;
    d2_addr = 19'h00124;
    d2_min = 32'h0BADF00D;
    @(posedge clock);
    #1 d2_req = 1'b0;
    a_seen = '0;
    lat = 1;
    repeat (40) begin
      @(negedge clock);
      if (d2_done) break;
      if (lat == 1) a_seen = d2_maddr;
      d2_min = (lat == 4) ? 32'hCAFEF00D : 32'h10000000 + lat;
      lat++;
    end
    if (!d2_done) lat = -1;
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat) begin
      errors++;
      $display("FAIL rw3_lat got %0d want %0d", lat, e.lat);
    end
    checks++;
    if (d2_rdata !== e.rd) begin
      errors++;
      $display("FAIL rw3_rdata got %h want %h", d2_rdata, e.rd);
    end
    checks++;
    if (a_seen !== 17'h00049) begin
      errors++;
      $display("FAIL rw3_addr got %h want 00049", a_seen);
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int lat;
    sb.push_back('{32'h600DCAFE, 2});
    @(negedge clock);
    req = 1'b1;
    op = OP_WRW;
    byte_addr = 19'h00040;
    wdata = 32'h600DCAFE;
    @(posedge clock);
    @(negedge clock);
    op = OP_WRD;
    wdata = 32'h0;
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clock);
      lat++;
    end
    checks++;
    if (lat !== 2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first lat %0d busy %b want 2/0", lat, busy);
    end
    @(posedge clock);
    #1 req = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept busy %b want 1", busy);
    end
    wait_done(lat);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat || rdata !== e.rd) begin
      errors++;
      $display("FAIL b2b_second got %h lat %0d want %h lat %0d",
               rdata, lat, e.rd, e.lat);
    end
  endtask

  task automatic test_reset_merge;
    int seen_done;
    @(negedge clock);
    mem[17'h010] = 32'h11223344;
    drive(OP_WRB, 19'h00041, 32'h000000BB);
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (mem_write_en !== 1'b1) begin
      errors++;
      $display("FAIL merge_we got %b want 1", mem_write_en);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (mem_write_en !== 1'b0) begin
      errors++;
      $display("FAIL rst_we got %b want 0", mem_write_en);
    end
    seen_done = 0;
    repeat (3) begin
      @(negedge clock);
      if (done) seen_done++;
    end
    reset = 1'b0;
    repeat (2) begin
      @(negedge clock);
      if (done) seen_done++;
    end
    checks++;
    if (mem[17'h010] !== 32'h11223344 || seen_done !== 0) begin
      errors++;
      $display("FAIL rst_abort mem %h done %0d want 11223344/0",
               mem[17'h010], seen_done);
    end
  endtask

`ifdef SIM_HALT_EN
  task automatic test_halt;
    int bad;
    drive(OP_WRW, 19'h00400, 32'h00010001);
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (halted !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL halt_set halted %b busy %b want 1/1",
               halted, busy);
    end
    req = 1'b1;
    op = OP_WRD;
    byte_addr = 19'h00040;
    bad = 0;
    repeat (6) begin
      @(negedge clock);
      if (busy !== 1'b1 || done !== 1'b0 ||
          mem_address !== 17'h00100) bad++;
    end
    req = 1'b0;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL halt_block got %0d bad cycles want 0", bad);
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (halted !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL halt_clear halted %b busy %b want 0/0",
               halted, busy);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    req = 1'b0;
    op = 2'b00;
    byte_addr = '0;
    wdata = '0;
    d2_req = 1'b0;
    d2_op = 2'b00;
    d2_addr = '0;
    d2_wdata = '0;
    d2_min = '0;
    test_reset();
    test_word();
    test_byte_read();
    test_byte_write();
    test_read_wait();
    test_back_to_back();
    test_reset_merge();
`ifdef SIM_HALT_EN
    test_halt();
`endif
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_initiator.md
Name: mem_initiator

Overview:
Bus-initiator end of the CPU-to-memory word interface: accepts single-beat requests from the CPU core and drives the word memory port.
- Memory port: 17-bit word address [15:31], combinational read data, write committed on the clock edge while write enable is high.
- Adds a byte view on top of the word memory: byte reads by lane extraction, byte writes by read-modify-write.
- Sits between the CPU datapath and the memory model or RAM; it is the only driver of the memory bus.

Parameters:
- READ_WAIT, 0: extra wait cycles between presenting the address and capturing read data, 0..15.
- HALT_ADDR, 17'h00100: word address watched by the optional halt detector.
- HALT_DATA, 32'h00010001: data value watched by the optional halt detector.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high.
- req  in  1  request strobe, sampled only while busy=0.
- op  in  [0:1]  00 word read, 01 byte read, 10 word write, 11 byte write.
- byte_addr  in  [13:31]  byte address. Word address is [13:29]; byte lane is [30:31], lane 0 = bits 0:7 (big-endian).
- wdata  in  [0:31]  write data; byte writes use bits 24:31.
- busy  out  1  request in progress.
- done  out  1  one-cycle completion pulse.
- rdata  out  [0:31]  read result; byte reads are zero-extended into bits 24:31.
- mem_address  out  [15:31]  word address to memory.
- mem_write_en  out  1  memory write enable.
- mem_data_out  out  [0:31]  write data to memory.
- mem_data_in  in  [0:31]  read data from memory.
- halted  out  1  present only with SIM_HALT_EN.

Behaviour:
- Reset values: busy=0, done=0, rdata=0, mem_address=0, mem_write_en=0, mem_data_out=0, halted=0. State=IDLE, wait counter=0.
- Reset asserted mid-transaction aborts it immediately:
  - mem_write_en drops asynchronously; no partial write commits after reset.
  - No done pulse is issued for the aborted transaction.
- All memory-side outputs are decoded from registered state and latched fields; no combinational path from req/op/wdata to the memory bus.
- States: IDLE, ACCESS, MERGE, DONE.
- IDLE:
  - On req=1, latch op, byte_addr, wdata; load counter=READ_WAIT; go to ACCESS.
  - busy rises in the cycle after req is sampled.
- ACCESS:
  - mem_address = latched word address.
  - Word write: mem_write_en=1 and mem_data_out=wdata for exactly one cycle, then DONE.
  - Reads and byte write: mem_write_en=0; decrement counter each cycle. When counter=0, capture mem_data_in.
    - Word read: rdata = full word, then DONE.
    - Byte read: rdata = {24'b0, selected lane}, then DONE.
    - Byte write: hold the captured word internally, go to MERGE.
- MERGE (byte write only): mem_data_out = captured word with the addressed lane replaced by wdata[24:31]; mem_write_en=1 for one cycle; then DONE.
- DONE: done=1 and busy=0 for one cycle; then IDLE.
  - A req present in the DONE cycle is accepted, giving back-to-back transactions.
- req while busy=1 is ignored; the requester holds req until it is accepted.
- rdata holds its value until the next read completes; writes leave it unchanged.
- Latency from req sample edge to done high:
  - word write: 2 cycles
  - word read / byte read: 2+READ_WAIT cycles
  - byte write: 3+READ_WAIT cycles
- Address wrap is the memory's concern; this block passes all 17 word-address bits unmodified.

Optional Feature:
- Macro: SIM_HALT_EN.
- Defined:
  - When a committed write (mem_write_en=1 at a clock edge) has mem_address==HALT_ADDR and mem_data_out==HALT_DATA, halted sets the following cycle. It is sticky until reset.
  - While halted=1, busy is held at 1 and no requests are accepted.
  - Byte writes that merge to HALT_DATA also trigger.
- Not defined: the halted port and the detector logic are absent; all other behaviour is identical.

Decomposition:
- Package mem_bus_pkg:
  - op encodings OP_WRD, OP_RDB, OP_WRW, OP_WRB
  - state encodings
  - word-address and byte-address widths
- One combinational sub-module, byte_lane: lane extract for reads and lane merge for writes, given word, lane and byte. It is reused by the CPU's byte-shift path.

Test Plan:
- Word write 0xDEADBEEF to byte_addr 0x00040, then word read of 0x00040 -> memory word 0x010 = 0xDEADBEEF; rdata=0xDEADBEEF; done at +2 cycles for each (READ_WAIT=0).
- Memory word 0x010 = 0x11223344; byte reads at lanes 0..3 -> rdata = 0x11, 0x22, 0x33, 0x44 zero-extended.
- Byte write 0xAA to byte_addr 0x00042 over 0x11223344 -> word becomes 0x1122AA44; mem_write_en high exactly one cycle; done at +3.
- READ_WAIT=3: word read -> capture occurs 3 cycles after the address is presented; done at +5. Changing mem_data_in before the capture cycle must not affect rdata.
- Back-to-back: req held high across DONE -> second transaction accepted in the DONE cycle. Also: reset asserted during MERGE -> mem_write_en low immediately, memory unchanged, no done pulse.
- With SIM_HALT_EN: write 0x00010001 to word 0x100 (byte_addr 0x00400) -> halted=1 next cycle; a following req is not accepted, busy stays 1; reset clears halted.
